// File: rtl/ob_pair_driver_if.sv
// ob_pair_driver_if
//   Bundles the stimulus/response and result signals between the OB pair
//   driver/checker and its surroundings (circuit pair plus reporting logic).
//   master : the driver/checker (drives I and the verdict, reads the CUT outputs)
//   slave  : the wrapper side (drives start/num_vec and the CUT outputs)
//   Signals:
//     start, num_vec          run request and number of compared vectors
//     I                       stimulus to both CUTs
//     a_O, b_O                outputs of CUT A and CUT B
//     busy, done, pass        run status and verdict
//     mism_cnt                count of mismatching compared vectors (saturating)
//     first_fail_idx/_I/_a/_b snapshot of the first mismatching vector
`timescale 1ns/1ps
interface ob_pair_driver_if #(
    parameter int N_IN  = 2,
    parameter int N_OUT = 2
);
    logic              start;
    logic [15:0]       num_vec;
    logic [N_IN-1:0]   I;
    logic [N_OUT-1:0]  a_O;
    logic [N_OUT-1:0]  b_O;
    logic              busy;
    logic              done;
    logic              pass;
    logic [15:0]       mism_cnt;
    logic [15:0]       first_fail_idx;
    logic [N_IN-1:0]   first_fail_I;
    logic [N_OUT-1:0]  first_fail_a;
    logic [N_OUT-1:0]  first_fail_b;

    modport master (
        input  start, num_vec, a_O, b_O,
        output I, busy, done, pass, mism_cnt,
               first_fail_idx, first_fail_I, first_fail_a, first_fail_b
    );

    modport slave (
        output start, num_vec, a_O, b_O,
        input  I, busy, done, pass, mism_cnt,
               first_fail_idx, first_fail_I, first_fail_a, first_fail_b
    );
endinterface

// File: rtl/ob_pair_driver.sv
// ob_pair_driver
//   Drives LFSR-generated vectors onto the shared inputs of two circuits under
//   test and compares their outputs every cycle. The first WARMUP vectors are
//   applied without comparison; the following num_vec vectors are compared.
//   Reports pass/fail, a saturating mismatch count and the first failing vector.
//   Ports:
//     CLK    clock, rising edge
//     RST_N  asynchronous active-low reset
//     bus    ob_pair_driver_if.master (start/num_vec in, I out, a_O/b_O in,
//            busy/done/pass/mism_cnt/first_fail_* out)
`timescale 1ns/1ps
module ob_pair_driver #(
    parameter int          N_IN   = 2,
    parameter int          N_OUT  = 2,
    parameter logic [15:0] SEED   = 16'hACE1,
    parameter int          WARMUP = 1
) (
    input  logic              CLK,
    input  logic              RST_N,
    ob_pair_driver_if.master  bus
);
    typedef enum logic [1:0] {IDLE, WARM, RUN, DONE} state_t;

    // An all-zero LFSR would lock up, so a zero seed is replaced.
    localparam logic [15:0] SEED_EFF  = (SEED == 16'h0000) ? 16'h0001 : SEED;
    localparam logic [15:0] WARM_LAST = (WARMUP > 0) ? 16'(WARMUP - 1) : '0;

    state_t            state;
    logic [15:0]       lfsr;
    logic [15:0]       vec_cnt;
    logic [15:0]       num_vec_r;
    logic              busy_r;
    logic              done_r;
    logic              pass_r;
    logic [15:0]       mism_cnt_r;
    logic [15:0]       ff_idx_r;
    logic [N_IN-1:0]   ff_i_r;
    logic [N_OUT-1:0]  ff_a_r;
    logic [N_OUT-1:0]  ff_b_r;

    logic [15:0]       lfsr_next;
    logic              mism;

    // x^16+x^14+x^13+x^11+1, Fibonacci form shifting right.
    assign lfsr_next = {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]};
    assign mism      = (bus.a_O != bus.b_O);

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state      <= IDLE;
            lfsr       <= SEED_EFF;
            vec_cnt    <= '0;
            num_vec_r  <= '0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            pass_r     <= 1'b0;
            mism_cnt_r <= '0;
            ff_idx_r   <= '0;
            ff_i_r     <= '0;
            ff_a_r     <= '0;
            ff_b_r     <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (bus.start) begin
                        lfsr       <= SEED_EFF;
                        vec_cnt    <= '0;
                        num_vec_r  <= bus.num_vec;
                        mism_cnt_r <= '0;
                        ff_idx_r   <= '0;
                        ff_i_r     <= '0;
                        ff_a_r     <= '0;
                        ff_b_r     <= '0;
                        if (bus.num_vec == 16'd0) begin
                            state  <= DONE;
                            busy_r <= 1'b0;
                            done_r <= 1'b1;
                            pass_r <= 1'b1;
                        end else begin
                            state  <= (WARMUP == 0) ? RUN : WARM;
                            busy_r <= 1'b1;
                            done_r <= 1'b0;
                            pass_r <= 1'b0;
                        end
                    end
                end
                WARM: begin
                    lfsr <= lfsr_next;
                    if (vec_cnt == WARM_LAST) begin
                        vec_cnt <= '0;
                        state   <= RUN;
                    end else begin
                        vec_cnt <= vec_cnt + 16'd1;
                    end
                end
                RUN: begin
                    lfsr <= lfsr_next;
                    if (mism) begin
                        if (mism_cnt_r != 16'hFFFF)
                            mism_cnt_r <= mism_cnt_r + 16'd1;
                        // Count never wraps back to zero, so zero means "no capture yet".
                        if (mism_cnt_r == 16'd0) begin
                            ff_idx_r <= vec_cnt;
                            ff_i_r   <= bus.I;
                            ff_a_r   <= bus.a_O;
                            ff_b_r   <= bus.b_O;
                        end
                    end
                    if (vec_cnt == num_vec_r - 16'd1) begin
                        state  <= DONE;
                        busy_r <= 1'b0;
                        done_r <= 1'b1;
                        // Include the final vector's own compare in the verdict.
                        pass_r <= (mism_cnt_r == 16'd0) && !mism;
                    end else begin
                        vec_cnt <= vec_cnt + 16'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.I              = busy_r ? lfsr[N_IN-1:0] : '0;
    assign bus.busy           = busy_r;
    assign bus.done           = done_r;
    assign bus.pass           = pass_r;
    assign bus.mism_cnt       = mism_cnt_r;
    assign bus.first_fail_idx = ff_idx_r;
    assign bus.first_fail_I   = ff_i_r;
    assign bus.first_fail_a   = ff_a_r;
    assign bus.first_fail_b   = ff_b_r;
endmodule

// File: doc/ob_pair_driver.md
# ob_pair_driver

Self-checking stimulus/response harness for the OB equivalence test circuits: generates pseudo-random input vectors from an LFSR, drives them onto the shared inputs of two circuits under test (A and B), and compares their outputs each cycle. It reports a pass/fail verdict, a mismatch count, and a snapshot of the first failing vector. It is the driver/checker end of the I/O interface that the TopLevel test circuits receive on, and it sits in the simulation and FPGA bring-up wrapper around a circuit pair.

## Interface
- N_IN, 2, number of CUT inputs (I bus width), 1..16
- N_OUT, 2, number of CUT outputs per circuit, 1..16
- SEED, 16'hACE1, LFSR load value on each start; 0 is illegal and is replaced by 16'h0001
- WARMUP, 1, vectors applied before comparison starts, covering the unknown CUT flop state; 0..255

- CLK  in  1  clock; all state updates on the rising edge
- RST_N  in  1  asynchronous active-low reset
- start  in  1  one-cycle request to begin a run; honoured only when not busy
- num_vec  in  16  number of compared vectors; sampled on the accepted start
- I  out  N_IN  stimulus to both CUTs
- a_O  in  N_OUT  outputs of CUT A
- b_O  in  N_OUT  outputs of CUT B
- busy  out  1  run in progress
- done  out  1  run finished; held until the next accepted start
- pass  out  1  valid when done=1; 1 = zero mismatches
- mism_cnt  out  16  compared vectors with a_O != b_O; saturates at 16'hFFFF
- first_fail_idx  out  16  compared-vector index of the first mismatch
- first_fail_I  out  N_IN  stimulus at the first mismatch
- first_fail_a  out  N_OUT  a_O at the first mismatch
- first_fail_b  out  N_OUT  b_O at the first mismatch

## Operation
- Reset values: state IDLE, lfsr=SEED, I=0, busy=0, done=0, pass=0, mism_cnt=0, all first_fail_* = 0.
- States:
  - IDLE: wait for start.
  - WARM: apply vectors without comparing.
  - RUN: apply and compare vectors.
  - DONE: report; waits for start as in IDLE.
- Transitions:
  - IDLE/DONE + start, num_vec > 0: go to WARM, or to RUN if WARMUP = 0. Load lfsr=SEED. Clear mism_cnt, first_fail_*, done, pass. Set busy=1.
  - IDLE/DONE + start, num_vec = 0: go directly to DONE with pass=1 and mism_cnt=0.
  - WARM: go to RUN after WARMUP vectors.
  - RUN: go to DONE on the edge that samples compared vector num_vec-1.
- LFSR: 16-bit Fibonacci, x^16+x^14+x^13+x^11+1.
  - Shift right by 1; the new bit 15 is b0^b2^b3^b5.
  - Advances once per busy cycle.
  - I = busy ? lfsr[N_IN-1:0] : 0.
- Compare: a_O and b_O are sampled at the end of the cycle in which I is applied.
  - Mismatch: any bit of a_O differs from b_O.
  - Warm vectors are never compared.
- On the first mismatch of a run, capture the compared index, I, a_O and b_O. Later mismatches only increment mism_cnt.
- start while busy is ignored. Changes to num_vec while busy are ignored.
- RST_N low at any point, including mid-run, immediately forces all reset values. No partial result is retained.

## Timing
- Start accepted on edge t0; busy=1 and I carries vector 0 from cycle t0+1.
- Vector k is applied during cycle t0+1+k, for k = 0..WARMUP+num_vec-1.
- Total busy cycles = WARMUP + num_vec.
- On the edge ending the last vector: busy falls, done rises, pass = (final mism_cnt == 0). All update in the same cycle.
- num_vec = 0: done=1 from cycle t0+1; busy never asserts.
- The CUT output path is combinational from I within one cycle. The CUTs' own flops share CLK.

## Test plan
- Reset: hold RST_N=0 with start=1 and random a_O/b_O.
  - Required: I=0, busy=0, done=0, pass=0, mism_cnt=0, first_fail_*=0.
- Seed sequence: start with SEED=16'hACE1, N_IN=2.
  - Required: I = 2'b01, 2'b00, 2'b00, 2'b00 on the first four busy cycles (lfsr ACE1, 5670, AB38, 559C).
- Equivalent pair: b_O tied to a_O, WARMUP=1, num_vec=100.
  - Required: busy for exactly 101 cycles, then done=1, pass=1, mism_cnt=0.
- Injected fault: num_vec=20; the bench flips b_O[1] on compared vectors 5..9.
  - Required: mism_cnt=5, pass=0, first_fail_idx=5.
  - Required: first_fail_I, first_fail_a and first_fail_b equal the values seen on vector 5.
- Warm masking and num_vec=0:
  - Mismatch injected only on the warm vector: pass=1.
  - start with num_vec=0: done=1 one cycle later, pass=1, busy never 1.
  - start pulsed mid-run: no effect.
- Reset mid-run: RST_N pulsed low during compared vector 10.
  - Required: all outputs return to reset values.
  - Required: the next start reproduces the I sequence 01, 00, 00, 00 and a fresh mism_cnt.
